// File: rtl/sifo_pkg.sv
// Shared widths, opcode/state encodings and instruction field helpers for the SIFO CPU core.
package sifo_pkg;

  localparam int unsigned DATA_W   = 10;
  localparam int unsigned ADDR_W   = 14;
  localparam int unsigned INSTR_W  = 30;
  localparam int unsigned REG_AW   = 4;
  localparam int unsigned NUM_REGS = 1 << REG_AW;

  typedef enum logic [4:0] {
    OP_NOP  = 5'd0,
    OP_HALT = 5'd1,
    OP_LD   = 5'd2,
    OP_ST   = 5'd3,
    OP_LDI  = 5'd4,
    OP_ADD  = 5'd5,
    OP_SUB  = 5'd6,
    OP_CMP  = 5'd7,
    OP_JMP  = 5'd8,
    OP_JG   = 5'd9,
    OP_JS   = 5'd10,
    OP_PUSH = 5'd11,
    OP_POP  = 5'd12,
    OP_AND  = 5'd13,
    OP_OR   = 5'd14
  } opcode_t;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  // Raw opcode bits; unlisted encodings must stay representable so they fall through as NOP.
  function automatic logic [4:0] f_op(input logic [INSTR_W-1:0] instr);
    return instr[29:25];
  endfunction

  function automatic logic [REG_AW-1:0] f_rd(input logic [INSTR_W-1:0] instr);
    return instr[24:21];
  endfunction

  function automatic logic [REG_AW-1:0] f_rs(input logic [INSTR_W-1:0] instr);
    return instr[20:17];
  endfunction

  function automatic logic [ADDR_W-1:0] f_addr(input logic [INSTR_W-1:0] instr);
    return instr[13:0];
  endfunction

endpackage

// File: rtl/sifo_stack.sv
// Small LIFO of DATA_W-bit entries; push when full and pop when empty are ignored.
module sifo_stack
  import sifo_pkg::*;
#(
  parameter int unsigned DEPTH = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [CW-1:0]     cnt_q, cnt_d;

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign dout  = empty ? '0 : mem_q[cnt_q - 1'b1];

  always_comb begin
    mem_d = mem_q;
    cnt_d = cnt_q;
    if (push && !full) begin
      mem_d[cnt_q] = din;
      cnt_d        = cnt_q + 1'b1;
    end else if (pop && !empty) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/sifo_microprocessor.sv
// Multi-cycle SIFO accumulator CPU: FETCH/DECODE/EXEC/MEM/HALT FSM, 16 registers, G/S flags.
// Define SIFO_STACK_EN to build the hardware stack; otherwise PUSH/POP behave as NOP.
module sifo_microprocessor
  import sifo_pkg::*;
#(
  parameter int unsigned STACK_DEPTH = 7
) (
  input  logic               clk,
  input  logic               rst,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [ADDR_W-1:0]  dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  output logic               dmem_we,
  output logic               dmem_re,
  input  logic [DATA_W-1:0]  dmem_rdata,
  input  logic               mem_stall,
  output logic [ADDR_W-1:0]  d_pc,
  output logic [INSTR_W-1:0] d_instr,
  output logic [2:0]         d_state,
  output logic               d_g,
  output logic               d_s,
  output logic               d_clk_en
);

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0]   ir_q, ir_d;
  logic [DATA_W-1:0]    regs_q [NUM_REGS];
  logic [DATA_W-1:0]    regs_d [NUM_REGS];
  logic                 g_q, g_d, s_q, s_d;
  logic                 clk_en_q, clk_en_d;
  logic [ADDR_W-1:0]    dmem_addr_q, dmem_addr_d;
  logic [DATA_W-1:0]    dmem_wdata_q, dmem_wdata_d;
  logic                 dmem_we_q, dmem_we_d, dmem_re_q, dmem_re_d;

  logic [4:0]           op, dec_op;
  logic [REG_AW-1:0]    rd, rs;
  logic [DATA_W-1:0]    rd_val, rs_val;

  assign op     = f_op(ir_q);
  assign rd     = f_rd(ir_q);
  assign rs     = f_rs(ir_q);
  assign rd_val = regs_q[rd];
  assign rs_val = regs_q[rs];
  assign dec_op = f_op(imem_data);

`ifdef SIFO_STACK_EN
  logic              stk_push, stk_pop, stk_full, stk_empty;
  logic [DATA_W-1:0] stk_dout;

  sifo_stack #(.DEPTH(STACK_DEPTH)) u_stack (
    .clk   (clk),
    .rst_n (rst),
    .push  (stk_push),
    .pop   (stk_pop),
    .din   (rd_val),
    .dout  (stk_dout),
    .full  (stk_full),
    .empty (stk_empty)
  );
`endif

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    regs_d       = regs_q;
    g_d          = g_q;
    s_d          = s_q;
    clk_en_d     = clk_en_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    dmem_we_d    = dmem_we_q;
    dmem_re_d    = dmem_re_q;
`ifdef SIFO_STACK_EN
    stk_push     = 1'b0;
    stk_pop      = 1'b0;
`endif
    if (!mem_stall) begin
      case (state_q)
        S_FETCH: state_d = S_DECODE;
        // Memory strobes are registered, so they are set up from the incoming
        // word here and are then valid for exactly the EXEC cycle(s).
        S_DECODE: begin
          ir_d      = imem_data;
          dmem_we_d = (dec_op == OP_ST);
          dmem_re_d = (dec_op == OP_LD);
          if (dec_op == OP_ST || dec_op == OP_LD) begin
            dmem_addr_d  = f_addr(imem_data) + ADDR_W'(regs_q[f_rs(imem_data)]);
            dmem_wdata_d = regs_q[f_rd(imem_data)];
          end
          state_d = S_EXEC;
        end
        S_EXEC: begin
          dmem_we_d = 1'b0;
          dmem_re_d = 1'b0;
          pc_d      = pc_q + 1'b1;
          state_d   = S_FETCH;
          case (op)
            OP_HALT: begin
              pc_d     = pc_q;
              clk_en_d = 1'b0;
              state_d  = S_HALT;
            end
            OP_LD:  state_d    = S_MEM;
            OP_LDI: regs_d[rd] = ir_q[DATA_W-1:0];
            OP_ADD: regs_d[rd] = rd_val + rs_val;
            OP_SUB: begin
              regs_d[rd] = rd_val - rs_val;
              g_d        = (rd_val > rs_val);
              s_d        = (rd_val < rs_val);
            end
            OP_CMP: begin
              g_d = (rd_val > rs_val);
              s_d = (rd_val < rs_val);
            end
            OP_JMP: pc_d = f_addr(ir_q);
            OP_JG:  if (g_q) pc_d = f_addr(ir_q);
            OP_JS:  if (s_q) pc_d = f_addr(ir_q);
`ifdef SIFO_STACK_EN
            OP_PUSH: stk_push = !stk_full;
            OP_POP: begin
              regs_d[rd] = stk_empty ? '0 : stk_dout;
              stk_pop    = !stk_empty;
            end
`endif
            OP_AND: regs_d[rd] = rd_val & rs_val;
            OP_OR:  regs_d[rd] = rd_val | rs_val;
            default: ;
          endcase
        end
        S_MEM: begin
          regs_d[rd] = dmem_rdata;
          state_d    = S_FETCH;
        end
        default: state_d = S_HALT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_FETCH;
      pc_q         <= '0;
      ir_q         <= '0;
      g_q          <= 1'b0;
      s_q          <= 1'b0;
      clk_en_q     <= 1'b1;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      dmem_we_q    <= 1'b0;
      dmem_re_q    <= 1'b0;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      g_q          <= g_d;
      s_q          <= s_d;
      clk_en_q     <= clk_en_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      dmem_we_q    <= dmem_we_d;
      dmem_re_q    <= dmem_re_d;
      regs_q       <= regs_d;
    end
  end

  assign imem_addr  = pc_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_wdata = dmem_wdata_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_re    = dmem_re_q;
  assign d_pc       = pc_q;
  assign d_instr    = ir_q;
  assign d_state    = state_q;
  assign d_g        = g_q;
  assign d_s        = s_q;
  assign d_clk_en   = clk_en_q;

endmodule

// File: tb/tb_sifo_microprocessor.sv
// Directed bench for sifo_microprocessor: small programs with hand-computed store logs and PC/flag values.
module tb_sifo_microprocessor;

  localparam logic [4:0] NOP = 5'd0, HALT = 5'd1, LD = 5'd2, ST = 5'd3, LDI = 5'd4,
                         ADD = 5'd5, SUB = 5'd6, CMP = 5'd7, JMP = 5'd8, JG = 5'd9,
                         JS = 5'd10, PUSH = 5'd11, POP = 5'd12;

  logic        clk = 1'b0;
  logic        rst;
  logic [13:0] imem_addr;
  logic [29:0] imem_data;
  logic [13:0] dmem_addr;
  logic [9:0]  dmem_wdata;
  logic        dmem_we, dmem_re;
  logic [9:0]  dmem_rdata;
  logic        mem_stall;
  logic [13:0] d_pc;
  logic [29:0] d_instr;
  logic [2:0]  d_state;
  logic        d_g, d_s, d_clk_en;

  sifo_microprocessor #(.STACK_DEPTH(7)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_we    (dmem_we),
    .dmem_re    (dmem_re),
    .dmem_rdata (dmem_rdata),
    .mem_stall  (mem_stall),
    .d_pc       (d_pc),
    .d_instr    (d_instr),
    .d_state    (d_state),
    .d_g        (d_g),
    .d_s        (d_s),
    .d_clk_en   (d_clk_en)
  );

  always #5 clk = ~clk;

  logic [29:0] imem [16384];
  logic [9:0]  drom [16384];
  logic [13:0] wr_addr [64];
  logic [9:0]  wr_data [64];
  int unsigned wr_n;

  always @(posedge clk) begin
    imem_data <= imem[imem_addr];
    if (!rst) begin
      wr_n <= 0;
    end else if (!mem_stall) begin
      if (dmem_re) dmem_rdata <= drom[dmem_addr];
      if (dmem_we) begin
        wr_addr[wr_n[5:0]] <= dmem_addr;
        wr_data[wr_n[5:0]] <= dmem_wdata;
        wr_n <= wr_n + 1;
      end
    end
  end

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [29:0] enc(input logic [4:0] op, input logic [3:0] rd,
                                      input logic [3:0] rs, input logic [13:0] a);
    return {op, rd, rs, 3'b000, a};
  endfunction

  task automatic hold_reset();
    rst       = 1'b0;
    mem_stall = 1'b0;
    for (int i = 0; i < 16384; i++) begin
      imem[i] = '0;
      drom[i] = '0;
    end
    @(negedge clk);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run_halt(input int unsigned budget);
    int unsigned k = 0;
    while (d_clk_en && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("halt_reached", d_clk_en, 0);
  endtask

  task automatic check_wr(input string tag, input int unsigned idx,
                          input int unsigned a, input int unsigned d);
    check({tag, "_addr"}, wr_addr[idx], a);
    check({tag, "_data"}, wr_data[idx], d);
  endtask

  initial begin
    int unsigned p;
    int unsigned k;
    logic found;

    // Reset state
    hold_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_pc", d_pc, 0);
    check("rst_state", d_state, 0);
    check("rst_clk_en", d_clk_en, 1);
    check("rst_we", dmem_we, 0);
    check("rst_re", dmem_re, 0);
    check("rst_daddr", dmem_addr, 0);

    // LDI/ADD/ST/HALT
    hold_reset();
    imem[0] = enc(LDI, 1, 0, 14'd5);
    imem[1] = enc(LDI, 2, 0, 14'd3);
    imem[2] = enc(ADD, 1, 2, 14'd0);
    imem[3] = enc(ST, 1, 0, 14'h100);
    imem[4] = enc(HALT, 0, 0, 14'd0);
    release_reset();
    run_halt(200);
    check("add_wr_n", wr_n, 1);
    check_wr("add_st", 0, 14'h100, 8);
    check("halt_pc", d_pc, 4);
    check("halt_state", d_state, 4);
    repeat (5) @(negedge clk);
    check("halt_pc_frozen", d_pc, 4);
    check("halt_clk_en_low", d_clk_en, 0);
    check("halt_no_more_wr", wr_n, 1);

    // CMP, JS taken, JG not taken
    hold_reset();
    imem[0]     = enc(LDI, 1, 0, 14'd5);
    imem[1]     = enc(LDI, 2, 0, 14'd3);
    imem[2]     = enc(CMP, 2, 1, 14'd0);
    imem[3]     = enc(JS, 0, 0, 14'h20);
    imem[4]     = enc(HALT, 0, 0, 14'd0);
    imem[14'h20] = enc(JG, 0, 0, 14'h30);
    imem[14'h21] = enc(HALT, 0, 0, 14'd0);
    imem[14'h30] = enc(HALT, 0, 0, 14'd0);
    release_reset();
    run_halt(200);
    check("cmp_pc", d_pc, 14'h21);
    check("cmp_s", d_s, 1);
    check("cmp_g", d_g, 0);

    // SUB sets G, JG taken; SUB wrap sets S
    hold_reset();
    imem[0] = enc(LDI, 1, 0, 14'd5);
    imem[1] = enc(LDI, 2, 0, 14'd3);
    imem[2] = enc(SUB, 1, 2, 14'd0);
    imem[3] = enc(JG, 0, 0, 14'd5);
    imem[4] = enc(HALT, 0, 0, 14'd0);
    imem[5] = enc(ST, 1, 0, 14'h40);
    imem[6] = enc(SUB, 0, 2, 14'd0);
    imem[7] = enc(ST, 0, 5, 14'h41);
    imem[8] = enc(HALT, 0, 0, 14'd0);
    release_reset();
    run_halt(200);
    check("sub_pc", d_pc, 8);
    check("sub_wr_n", wr_n, 2);
    check_wr("sub_pos", 0, 14'h40, 2);
    check_wr("sub_wrap", 1, 14'h41, 10'h3FD);
    check("sub_s", d_s, 1);
    check("sub_g", d_g, 0);

    // LD with index, ADD wrap, effective-address wrap
    hold_reset();
    drom[14'h12] = 10'h3FF;
    imem[0] = enc(LDI, 3, 0, 14'd2);
    imem[1] = enc(LD, 4, 3, 14'h10);
    imem[2] = enc(ST, 4, 0, 14'h50);
    imem[3] = enc(LDI, 5, 0, 14'd1);
    imem[4] = enc(ADD, 4, 5, 14'd0);
    imem[5] = enc(ST, 4, 0, 14'h51);
    imem[6] = enc(ST, 5, 5, 14'h3FFF);
    imem[7] = enc(HALT, 0, 0, 14'd0);
    release_reset();
    run_halt(200);
    check("ld_pc", d_pc, 7);
    check("ld_wr_n", wr_n, 3);
    check_wr("ld_val", 0, 14'h50, 10'h3FF);
    check_wr("add_wrap", 1, 14'h51, 0);
    check_wr("ea_wrap", 2, 0, 1);

    // PC wrap 0x3FFF -> 0
    hold_reset();
    imem[0]       = enc(JS, 0, 0, 14'd3);
    imem[1]       = enc(LDI, 1, 0, 14'd1);
    imem[2]       = enc(JMP, 0, 0, 14'h3FFF);
    imem[3]       = enc(HALT, 0, 0, 14'd0);
    imem[14'h3FFF] = enc(CMP, 0, 1, 14'd0);
    release_reset();
    run_halt(200);
    check("pcwrap_pc", d_pc, 3);
    check("pcwrap_s", d_s, 1);

    // Stack
    hold_reset();
`ifdef SIFO_STACK_EN
    p = 0;
    for (int i = 1; i <= 8; i++) imem[p++] = enc(LDI, 4'(i), 0, 14'(i));
    for (int i = 1; i <= 8; i++) imem[p++] = enc(PUSH, 4'(i), 0, 14'd0);
    for (int i = 0; i < 8; i++) begin
      imem[p++] = enc(POP, 9, 0, 14'd0);
      imem[p++] = enc(ST, 9, 0, 14'(14'h60 + i));
    end
    imem[p] = enc(HALT, 0, 0, 14'd0);
    release_reset();
    run_halt(400);
    check("stk_wr_n", wr_n, 8);
    for (int i = 0; i < 8; i++)
      check_wr($sformatf("stk_pop%0d", i), i, 14'h60 + i, (i < 7) ? 7 - i : 0);
`else
    imem[0] = enc(LDI, 1, 0, 14'd9);
    imem[1] = enc(POP, 1, 0, 14'd0);
    imem[2] = enc(PUSH, 1, 0, 14'd0);
    imem[3] = enc(POP, 1, 0, 14'd0);
    imem[4] = enc(ST, 1, 0, 14'h60);
    imem[5] = enc(HALT, 0, 0, 14'd0);
    release_reset();
    run_halt(200);
    check("nostk_pc", d_pc, 5);
    check("nostk_wr_n", wr_n, 1);
    check_wr("nostk_pop", 0, 14'h60, 9);
`endif

    // Stall during ST EXEC
    hold_reset();
    imem[0] = enc(LDI, 1, 0, 14'h55);
    imem[1] = enc(ST, 1, 0, 14'h70);
    imem[2] = enc(HALT, 0, 0, 14'd0);
    release_reset();
    found = 1'b0;
    k = 0;
    while (!found && k < 100) begin
      @(negedge clk);
      k++;
      if (d_state == 3'd2 && d_instr[29:25] == ST) found = 1'b1;
    end
    check("st_exec_found", found, 1);
    mem_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("stall%0d_we", i), dmem_we, 1);
      check($sformatf("stall%0d_pc", i), d_pc, 1);
      check($sformatf("stall%0d_state", i), d_state, 2);
      check($sformatf("stall%0d_wr_n", i), wr_n, 0);
    end
    mem_stall = 1'b0;
    run_halt(200);
    check("stall_wr_n", wr_n, 1);
    check_wr("stall_st", 0, 14'h70, 10'h55);
    check("stall_pc", d_pc, 2);

    // Reset mid-LD
    hold_reset();
    drom[14'h12] = 10'h2AA;
    imem[0] = enc(LDI, 3, 0, 14'd2);
    imem[1] = enc(LD, 4, 3, 14'h10);
    imem[2] = enc(HALT, 0, 0, 14'd0);
    release_reset();
    found = 1'b0;
    k = 0;
    while (!found && k < 100) begin
      @(negedge clk);
      k++;
      if (d_state == 3'd2 && d_instr[29:25] == LD) found = 1'b1;
    end
    check("ld_exec_found", found, 1);
    check("ld_exec_re", dmem_re, 1);
    check("ld_exec_addr", dmem_addr, 14'h12);
    @(negedge clk);
    check("ld_mem_state", d_state, 3);
    rst = 1'b0;
    #1;
    check("midrst_state", d_state, 0);
    check("midrst_pc", d_pc, 0);
    check("midrst_instr", d_instr, 0);
    check("midrst_re", dmem_re, 0);
    check("midrst_clk_en", d_clk_en, 1);
    release_reset();
    run_halt(200);
    check("midrst_rerun_pc", d_pc, 2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
